// File: rtl/cafe_pkg.sv
// Shared grading definitions for the bean path (classifier and sorter gate).
// Holds the grade codes, the sorter FSM state encoding and the grade-to-bin mapping.
// No logic of its own; imported by the blocks that need it.
package cafe_pkg;

    localparam logic [1:0] GRADE_BAJA    = 2'b00;
    localparam logic [1:0] GRADE_MEDIA   = 2'b01;
    localparam logic [1:0] GRADE_ALTA    = 2'b10;
    localparam logic [1:0] GRADE_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETTLE = 2'b01,
        ST_EJECT  = 2'b10,
        ST_GAP    = 2'b11
    } sorter_state_t;

    // An unknown grade goes to the reject bin so a classifier fault can
    // never promote a bean into a better grade.
    function automatic logic [1:0] grade_to_bin(input logic [1:0] g);
        return (g == GRADE_ILLEGAL) ? GRADE_BAJA : g;
    endfunction

endpackage

// File: rtl/bean_sorter_gate_if.sv
// Grade handshake between the classifier (master) and the sorter gate (slave).
// Latency: none, wires only.
// Backpressure: master holds grade stable while grade_valid && !grade_ready.
// Signals: grade_valid / grade[1:0] from master, grade_ready from slave.
interface bean_sorter_gate_if;

    logic       grade_valid;
    logic [1:0] grade;
    logic       grade_ready;

    modport master (
        output grade_valid,
        output grade,
        input  grade_ready
    );

    modport slave (
        input  grade_valid,
        input  grade,
        output grade_ready
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Latency: count reflects inc/clr one edge later.
// Backpressure: none; increments beyond all-ones are dropped.
// Ports: clk, rst_n (sync, active low), inc, clr, count[W-1:0].
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/bean_sorter_gate.sv
// Steers the diverter to the bean's grade bin, waits for settle, fires a timed eject pulse.
// Latency: eject rises SETTLE_CYCLES+1 edges after acceptance on a gate change, next edge otherwise.
// Backpressure: grade_ready only in IDLE; upstream stalls for the whole sort of one bean.
// Ports: clk, rst_n (sync, active low), up (grade handshake, slave), gate_sel, eject, busy,
//        bad_grade, cnt_clear, cnt_baja/cnt_media/cnt_alta (saturating per-bin eject counts).
module bean_sorter_gate
    import cafe_pkg::*;
#(
    parameter int SETTLE_CYCLES = 8,
    parameter int PULSE_CYCLES  = 4,
    parameter int CNT_W         = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    bean_sorter_gate_if.slave   up,
    output logic [1:0]          gate_sel,
    output logic                eject,
    output logic                busy,
    output logic                bad_grade,
    input  logic                cnt_clear,
    output logic [CNT_W-1:0]    cnt_baja,
    output logic [CNT_W-1:0]    cnt_media,
    output logic [CNT_W-1:0]    cnt_alta
);

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);
    localparam logic [7:0] PULSE_LOAD  = 8'(PULSE_CYCLES);

    sorter_state_t state_q, state_d;
    logic [7:0]    timer_q, timer_d;
    logic [1:0]    gate_d;
    logic          accept;
    logic [1:0]    bin;
    logic          enter_eject;

    assign accept = up.grade_valid && up.grade_ready;
    assign bin    = grade_to_bin(up.grade);

    // Timer counts down the cycles remaining in the current timed state;
    // the state is left on the edge where it reads 1.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        gate_d  = gate_sel;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    gate_d = bin;
                    if (bin != gate_sel) begin
                        state_d = ST_SETTLE;
                        timer_d = SETTLE_LOAD;
                    end else begin
                        state_d = ST_EJECT;
                        timer_d = PULSE_LOAD;
                    end
                end
            end
            ST_SETTLE: begin
                if (timer_q <= 8'd1) begin
                    state_d = ST_EJECT;
                    timer_d = PULSE_LOAD;
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end
            ST_EJECT: begin
                if (timer_q <= 8'd1) begin
                    state_d = ST_GAP;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            gate_sel  <= GRADE_BAJA;
            bad_grade <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            gate_sel  <= gate_d;
            bad_grade <= accept && (up.grade == GRADE_ILLEGAL);
        end
    end

    assign up.grade_ready = (state_q == ST_IDLE);
    assign busy           = (state_q != ST_IDLE);
    assign eject          = (state_q == ST_EJECT);

    // gate_d already names the destination bin on the edge entering EJECT,
    // whether that edge is the acceptance itself or the end of settle.
    assign enter_eject = (state_d == ST_EJECT) && (state_q != ST_EJECT);

    sat_counter #(.W(CNT_W)) u_cnt_baja (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (enter_eject && (gate_d == GRADE_BAJA)),
        .clr   (cnt_clear),
        .count (cnt_baja)
    );

    sat_counter #(.W(CNT_W)) u_cnt_media (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (enter_eject && (gate_d == GRADE_MEDIA)),
        .clr   (cnt_clear),
        .count (cnt_media)
    );

    sat_counter #(.W(CNT_W)) u_cnt_alta (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (enter_eject && (gate_d == GRADE_ALTA)),
        .clr   (cnt_clear),
        .count (cnt_alta)
    );

endmodule

// File: tb/tb_bean_sorter_gate.sv
// Bench for bean_sorter_gate: scoreboard of expected eject events per bean.
// Inputs driven and outputs sampled on the falling clock edge.
// Small counter width so saturation is reachable in a few beans.
module tb_bean_sorter_gate;

    localparam int S    = 8;
    localparam int P    = 4;
    localparam int W    = 2;
    localparam int CMAX = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cnt_clear = 1'b0;
    logic [1:0]   gate_sel;
    logic         eject, busy, bad_grade;
    logic [W-1:0] cnt_baja, cnt_media, cnt_alta;

    bean_sorter_gate_if gif ();

    bean_sorter_gate #(
        .SETTLE_CYCLES (S),
        .PULSE_CYCLES  (P),
        .CNT_W         (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .up        (gif.slave),
        .gate_sel  (gate_sel),
        .eject     (eject),
        .busy      (busy),
        .bad_grade (bad_grade),
        .cnt_clear (cnt_clear),
        .cnt_baja  (cnt_baja),
        .cnt_media (cnt_media),
        .cnt_alta  (cnt_alta)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    typedef struct {
        int gate;
        int lat;
        int bad;
        int baja;
        int media;
        int alta;
    } exp_t;

    exp_t sb[$];

    // Reference model of the gate position and the three counters.
    int m_gate  = 0;
    int m_baja  = 0;
    int m_media = 0;
    int m_alta  = 0;

    function automatic int sat_inc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic model_reset();
        m_gate = 0; m_baja = 0; m_media = 0; m_alta = 0;
    endtask

    task automatic check_counts(input string tag, input int b, input int m, input int a);
        check({tag, "_baja"},  int'(cnt_baja),  b);
        check({tag, "_media"}, int'(cnt_media), m);
        check({tag, "_alta"},  int'(cnt_alta),  a);
    endtask

    // Watches one bean from the cycle after acceptance until grade_ready returns.
    task automatic observe(input bit hold, input bit clr);
        int   k, width, badw, gate_bad, lat_exp, gate_exp;
        bit   popped;
        exp_t e;
        width = 0; badw = 0; gate_bad = 0; popped = 0;
        lat_exp  = sb[0].lat;
        gate_exp = sb[0].gate;
        for (k = 1; k <= 600; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (!hold) gif.grade_valid = 1'b0;
                check("gate_on_accept", int'(gate_sel), gate_exp);
            end
            if (cnt_clear) cnt_clear = 1'b0;
            if (eject) begin
                width++;
                if (int'(gate_sel) != gate_exp) gate_bad++;
            end
            if (eject && !popped) begin
                e = sb.pop_front();
                popped = 1'b1;
                check("eject_latency", k, e.lat);
            end
            if (bad_grade) badw++;
            if (clr && (k == lat_exp - 1)) cnt_clear = 1'b1;
            if (gif.grade_ready) break;
        end
        gif.grade_valid = 1'b0;
        if (!popped) begin
            check("eject_seen", 0, 1);
            e = sb.pop_front();
        end
        check("ready_return", k, e.lat + P + 1);
        check("eject_width", width, P);
        check("gate_stable_in_eject", gate_bad, 0);
        check("bad_grade_width", badw, e.bad);
        check_counts("cnt", e.baja, e.media, e.alta);
    endtask

    // Called on a falling edge with the DUT idle; returns on a falling edge.
    task automatic send_bean(input logic [1:0] g, input bit clr, input bit hold);
        exp_t e;
        int   tgt;
        tgt   = (g == 2'b11) ? 0 : int'(g);
        e.gate = tgt;
        e.lat  = (tgt != m_gate) ? S + 1 : 1;
        e.bad  = (g == 2'b11) ? 1 : 0;
        if (clr) begin
            m_baja = 0; m_media = 0; m_alta = 0;
        end else begin
            case (tgt)
                0: m_baja  = sat_inc(m_baja);
                1: m_media = sat_inc(m_media);
                default: m_alta = sat_inc(m_alta);
            endcase
        end
        m_gate  = tgt;
        e.baja  = m_baja;
        e.media = m_media;
        e.alta  = m_alta;
        sb.push_back(e);
        check("ready_before_send", int'(gif.grade_ready), 1);
        gif.grade       = g;
        gif.grade_valid = 1'b1;
        if (clr && e.lat == 1) cnt_clear = 1'b1;
        observe(hold, clr);
    endtask

    // ALTA bean from gate BAJA, reset either mid-pulse or on the edge entering EJECT.
    task automatic reset_during_bean(input bit at_entry);
        int  k;
        bit  fired;
        fired = 1'b0;
        gif.grade       = 2'b10;
        gif.grade_valid = 1'b1;
        for (k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) gif.grade_valid = 1'b0;
            if (at_entry ? (k == S) : (eject == 1'b1)) begin
                rst_n = 1'b0;
                fired = 1'b1;
                break;
            end
        end
        check(at_entry ? "rst_entry_reached" : "rst_pulse_reached", int'(fired), 1);
        @(negedge clk);
        check("rst_eject", int'(eject), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(gif.grade_ready), 1);
        check("rst_gate", int'(gate_sel), 0);
        check_counts("rst_cnt", 0, 0, 0);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        check("rst_ready_after", int'(gif.grade_ready), 1);
        check("rst_eject_after", int'(eject), 0);
    endtask

    initial begin
        gif.grade_valid = 1'b0;
        gif.grade       = 2'b00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_ready", int'(gif.grade_ready), 1);
        check("reset_gate", int'(gate_sel), 0);
        check("reset_eject", int'(eject), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_bad", int'(bad_grade), 0);
        check_counts("reset_cnt", 0, 0, 0);

        // Gate change 00 -> 10, then same gate with valid held through busy.
        send_bean(2'b10, 1'b0, 1'b0);
        send_bean(2'b10, 1'b0, 1'b1);
        @(negedge clk);
        check("no_double_accept", int'(busy), 0);
        check("no_double_count", int'(cnt_alta), 2);

        // Illegal code lands in BAJA with a single bad_grade pulse.
        send_bean(2'b11, 1'b0, 1'b0);
        send_bean(2'b01, 1'b0, 1'b0);

        // Four more BAJA beans (five in total with the illegal one) saturate.
        for (int i = 0; i < 4; i++) send_bean(2'b00, 1'b0, 1'b0);

        // Clear on the edge entering EJECT: the bean is not counted.
        send_bean(2'b00, 1'b1, 1'b0);
        // Clear on the settle-to-eject edge after a gate change.
        send_bean(2'b01, 1'b0, 1'b0);
        send_bean(2'b10, 1'b1, 1'b0);

        // Return gate to BAJA so the reset cases start with a gate change.
        send_bean(2'b00, 1'b0, 1'b0);
        reset_during_bean(1'b0);
        reset_during_bean(1'b1);

        // Normal operation after reset.
        send_bean(2'b01, 1'b0, 1'b0);

        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
